// File: rtl/cnn_mem_host_if.sv
// Host-side Avalon-MM initiator for the cnn_mem byte-wide slave port.
// Turns load commands plus a byte stream into same-address write bursts,
// and readback commands into single read cycles delivered on a
// ready/valid byte stream.
module cnn_mem_host_if #(
  parameter int ADDR_W       = 19,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [2:0]        cmd_region,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              av_chipselect,
  output logic              av_write,
  output logic              av_read,
  output logic [ADDR_W-1:0] av_address,
  output logic [7:0]        av_writedata,
  input  logic [7:0]        av_readdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LOAD, RD_ISSUE, RD_WAIT, RD_OUT, DONE} state_t;

  localparam logic [2:0] RL = 3'(READ_LATENCY);

  state_t            state, state_nxt;
  logic              started;
  logic [2:0]        region_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] rem_q;
  logic [2:0]        wait_cnt;
  logic              wr_vld_p1;
  logic [7:0]        wr_data_p1;
  logic              accept;
  logic              byte_acc;
  logic              last_idx;

  // started keeps cmd_ready low until the first clock after reset release
  assign cmd_ready     = started && (state == IDLE);
  assign accept        = cmd_valid && cmd_ready;
  assign s_ready       = (state == LOAD);
  assign byte_acc      = s_valid && s_ready;
  assign last_idx      = (idx_q == len_q - ADDR_W'(1));
  assign m_valid       = (state == RD_OUT);
  assign av_read       = (state == RD_ISSUE);
  assign av_write      = wr_vld_p1;
  assign av_chipselect = av_read || av_write;
  assign av_address    = av_read  ? idx_q :
                         av_write ? {{(ADDR_W-3){1'b0}}, region_q} : '0;
  assign av_writedata  = av_write ? wr_data_p1 : 8'h00;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // State register and post-reset start flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  // Next-state decision for command sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_len == '0) state_nxt = DONE;
          else if (cmd_op)   state_nxt = RD_ISSUE;
          else               state_nxt = LOAD;
        end
      end
      LOAD:     if (byte_acc && (rem_q == ADDR_W'(1))) state_nxt = DONE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (wait_cnt == RL) state_nxt = RD_OUT;
      RD_OUT:   if (m_ready) state_nxt = last_idx ? DONE : RD_ISSUE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Command context, byte/index counters and write-data stage
  always_ff @(posedge clk) begin
    if (accept) begin
      region_q <= cmd_region;
      len_q    <= cmd_len;
      rem_q    <= cmd_len;
      idx_q    <= '0;
    end
    if (byte_acc) rem_q <= rem_q - ADDR_W'(1);
    if (m_valid && m_ready && !last_idx) idx_q <= idx_q + ADDR_W'(1);
    wr_data_p1 <= s_data;
  end

  // Write strobe stage, read-latency counter and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_vld_p1 <= 1'b0;
      wait_cnt  <= '0;
      m_data    <= '0;
    end else begin
      wr_vld_p1 <= byte_acc;
      if (state == RD_ISSUE)     wait_cnt <= 3'd1;
      else if (state == RD_WAIT) wait_cnt <= wait_cnt + 3'd1;
      if ((state == RD_WAIT) && (wait_cnt == RL)) m_data <= av_readdata;
    end
  end

endmodule
